// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator key-entry stage and core.
package calc_pkg;

  localparam int unsigned NB_DEF   = 48;
  localparam int unsigned NDIG_DEF = 12;

  typedef enum logic [4:0] {
    KEY_0    = 5'd0,
    KEY_1    = 5'd1,
    KEY_2    = 5'd2,
    KEY_3    = 5'd3,
    KEY_4    = 5'd4,
    KEY_5    = 5'd5,
    KEY_6    = 5'd6,
    KEY_7    = 5'd7,
    KEY_8    = 5'd8,
    KEY_9    = 5'd9,
    KEY_ADD  = 5'd10,
    KEY_SUB  = 5'd11,
    KEY_MUL  = 5'd12,
    KEY_DIV  = 5'd13,
    KEY_POW  = 5'd14,
    KEY_EQ   = 5'd15,
    KEY_NEG  = 5'd16,
    KEY_CLR  = 5'd17,
    KEY_BKSP = 5'd18
  } key_code_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_POW = 3'd4
  } calc_op_e;

  typedef enum logic [1:0] {
    ENTRY_A = 2'd0,
    ENTRY_B = 2'd1,
    ISSUE   = 2'd2
  } entry_state_e;

  typedef enum logic [2:0] {
    ACC_NOP  = 3'd0,
    ACC_PUSH = 3'd1,
    ACC_BKSP = 3'd2,
    ACC_NEG  = 3'd3,
    ACC_CLR  = 3'd4
  } acc_cmd_e;

  // Operator keys 10..14 map onto operator codes 0..4.
  function automatic calc_op_e key_to_op(input logic [4:0] k);
    logic [4:0] idx;
    idx = k - 5'd10;
    return calc_op_e'(idx[2:0]);
  endfunction

endpackage

// File: rtl/calc_digit_acc.sv
// Decimal digit accumulator: magnitude, digit count and sign of one operand.
module calc_digit_acc
  import calc_pkg::*;
#(
  parameter int unsigned NB   = NB_DEF,
  parameter int unsigned NDIG = NDIG_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  acc_cmd_e             cmd,
  input  logic [3:0]           digit,
  output logic signed [NB-1:0] value,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned CW = $clog2(NDIG + 1);

  logic [NB-1:0] mag_q, mag_d;
  logic [CW-1:0] count_q, count_d;
  logic          sign_q, sign_d;
  logic [NB-1:0] mag_x10;

  assign mag_x10 = (mag_q << 3) + (mag_q << 1);
  assign full    = (count_q == CW'(NDIG));
  assign empty   = (count_q == '0);
  assign value   = sign_q ? -$signed(mag_q) : $signed(mag_q);

  always_comb begin
    mag_d   = mag_q;
    count_d = count_q;
    sign_d  = sign_q;
    case (cmd)
      ACC_PUSH: begin
        // A leading zero neither changes the value nor consumes a digit slot.
        if (!full && !(empty && digit == 4'd0)) begin
          mag_d   = mag_x10 + NB'(digit);
          count_d = count_q + 1'b1;
        end
      end
      ACC_BKSP: begin
        if (!empty) begin
          mag_d   = mag_q / NB'(10);
          count_d = count_q - 1'b1;
        end
      end
      ACC_NEG: sign_d = ~sign_q;
      ACC_CLR: begin
        mag_d   = '0;
        count_d = '0;
        sign_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q   <= '0;
      count_q <= '0;
      sign_q  <= 1'b0;
    end else begin
      mag_q   <= mag_d;
      count_q <= count_d;
      sign_q  <= sign_d;
    end
  end

endmodule

// File: rtl/calc_key_entry.sv
// Key-entry front end: builds A, operator and B from key codes and hands them to the core.
module calc_key_entry
  import calc_pkg::*;
#(
  parameter int unsigned NB   = NB_DEF,
  parameter int unsigned NDIG = NDIG_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  input  logic [4:0]           key_code,
  output logic                 key_ready,
  output logic signed [NB-1:0] a,
  output logic signed [NB-1:0] b,
  output logic [2:0]           operand,
  output logic                 op_valid,
  input  logic                 op_ready,
  output logic signed [NB-1:0] disp_value,
  output logic                 key_err
);

  entry_state_e          state_q, state_d;
  logic signed [NB-1:0]  a_q, a_d;
  logic signed [NB-1:0]  b_q, b_d;
  calc_op_e              op_q, op_d;
  logic                  key_err_q, key_err_d;

  acc_cmd_e              acc_cmd;
  logic signed [NB-1:0]  acc_value;
  logic                  acc_full;
  logic                  acc_empty;

  calc_digit_acc #(
    .NB   (NB),
    .NDIG (NDIG)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (acc_cmd),
    .digit (key_code[3:0]),
    .value (acc_value),
    .full  (acc_full),
    .empty (acc_empty)
  );

  assign key_ready  = (state_q != ISSUE);
  assign op_valid   = (state_q == ISSUE);
  assign a          = a_q;
  assign b          = b_q;
  assign operand    = op_q;
  assign disp_value = acc_value;
  assign key_err    = key_err_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    key_err_d = 1'b0;
    acc_cmd   = ACC_NOP;

    if (state_q == ISSUE) begin
      if (op_ready) begin
        state_d = ENTRY_A;
        a_d     = '0;
        b_d     = '0;
        op_d    = OP_ADD;
        acc_cmd = ACC_CLR;
      end
    end else if (key_valid) begin
      if (key_code <= KEY_9) begin
        if (acc_full) key_err_d = 1'b1;
        else          acc_cmd   = ACC_PUSH;
      end else begin
        case (key_code)
          KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV, KEY_POW: begin
            if (state_q == ENTRY_A) begin
              // A leaves the shared accumulator here; B reuses it from scratch.
              a_d     = acc_value;
              op_d    = key_to_op(key_code);
              state_d = ENTRY_B;
              acc_cmd = ACC_CLR;
            end else if (acc_empty) begin
              op_d = key_to_op(key_code);
            end else begin
              key_err_d = 1'b1;
            end
          end
          KEY_EQ: begin
            if (state_q == ENTRY_B) begin
              b_d     = acc_value;
              state_d = ISSUE;
            end else begin
              key_err_d = 1'b1;
            end
          end
          KEY_NEG:  acc_cmd = ACC_NEG;
          KEY_BKSP: acc_cmd = ACC_BKSP;
          KEY_CLR: begin
            state_d = ENTRY_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = OP_ADD;
            acc_cmd = ACC_CLR;
          end
          default: key_err_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ENTRY_A;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_ADD;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      key_err_q <= key_err_d;
    end
  end

endmodule

// File: tb/tb_calc_key_entry.sv
// Directed and randomized key sequences checked against a digit-list model of the entry stage.
module tb_calc_key_entry;

  localparam int NB   = 48;
  localparam int NDIG = 12;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 key_valid = 1'b0;
  logic [4:0]           key_code = '0;
  logic                 key_ready;
  logic signed [NB-1:0] a;
  logic signed [NB-1:0] b;
  logic [2:0]           operand;
  logic                 op_valid;
  logic                 op_ready = 1'b0;
  logic signed [NB-1:0] disp_value;
  logic                 key_err;

  int checks   = 0;
  int failures = 0;

  // Reference model: operand under entry kept as a list of decimal digits.
  int     m_state;   // 0 = entering A, 1 = entering B, 2 = waiting for the core
  int     m_digits[$];
  bit     m_sign;
  longint m_a, m_b;
  int     m_op;
  bit     m_err;

  calc_key_entry #(
    .NB   (NB),
    .NDIG (NDIG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .a          (a),
    .b          (b),
    .operand    (operand),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .disp_value (disp_value),
    .key_err    (key_err)
  );

  always #5 clk = ~clk;

  function automatic longint m_val();
    longint m = 0;
    foreach (m_digits[i]) m = m * 10 + m_digits[i];
    return m_sign ? -m : m;
  endfunction

  function automatic void m_clear_all();
    m_state = 0;
    m_digits.delete();
    m_sign = 0;
    m_a = 0;
    m_b = 0;
    m_op = 0;
  endfunction

  function automatic void m_update(input bit kv, input int code, input bit ordy);
    m_err = 0;
    if (m_state == 2) begin
      if (ordy) m_clear_all();
    end else if (kv) begin
      if (code <= 9) begin
        if (m_digits.size() == NDIG) m_err = 1;
        else if (!(m_digits.size() == 0 && code == 0)) m_digits.push_back(code);
      end else if (code >= 10 && code <= 14) begin
        if (m_state == 0) begin
          m_a = m_val();
          m_op = code - 10;
          m_state = 1;
          m_digits.delete();
          m_sign = 0;
        end else if (m_digits.size() == 0) begin
          m_op = code - 10;
        end else begin
          m_err = 1;
        end
      end else if (code == 15) begin
        if (m_state == 1) begin
          m_b = m_val();
          m_state = 2;
        end else begin
          m_err = 1;
        end
      end else if (code == 16) begin
        m_sign = !m_sign;
      end else if (code == 17) begin
        m_clear_all();
      end else if (code == 18) begin
        if (m_digits.size() > 0) void'(m_digits.pop_back());
      end else begin
        m_err = 1;
      end
    end
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".disp"}, disp_value, m_val());
    check({tag, ".a"}, a, m_a);
    check({tag, ".b"}, b, m_b);
    check({tag, ".operand"}, {1'b0, operand}, m_op);
    check({tag, ".op_valid"}, op_valid, (m_state == 2));
    check({tag, ".key_ready"}, key_ready, (m_state != 2));
    check({tag, ".key_err"}, key_err, m_err);
  endtask

  task automatic step(input string tag, input bit kv, input int code, input bit ordy);
    @(negedge clk);
    key_valid = kv;
    key_code  = 5'(code);
    op_ready  = ordy;
    @(posedge clk);
    m_update(kv, code, ordy);
    #1;
    key_valid = 1'b0;
    op_ready  = 1'b0;
    check_all(tag);
  endtask

  task automatic key(input string tag, input int code);
    step(tag, 1'b1, code, 1'b0);
  endtask

  initial begin
    m_clear_all();
    m_err = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    step("idle", 1'b0, 0, 1'b0);

    // 12 + 34, held by the core for 5 cycles, then consumed
    key("t1.k1", 1); key("t1.k2", 2); key("t1.add", 10);
    key("t1.k3", 3); key("t1.k4", 4); key("t1.eq", 15);
    check("t1.a12", a, 12);
    check("t1.b34", b, 34);
    for (int i = 0; i < 5; i++) step("t1.hold", 1'b1, 5, 1'b0);
    step("t1.consume", 1'b0, 0, 1'b1);
    check("t1.disp0", disp_value, 0);

    // Negative A, operator replaced before any B digit
    key("t2.k7", 7); key("t2.neg", 16); key("t2.sub", 11);
    key("t2.mul", 12); key("t2.k5", 5); key("t2.eq", 15);
    check("t2.a", a, -7);
    check("t2.op", {1'b0, operand}, 2);
    step("t2.consume", 1'b0, 0, 1'b1);

    // Thirteen nines: only the last is rejected
    for (int i = 0; i < 13; i++) key("t3.nine", 9);
    check("t3.disp", disp_value, 64'sd999999999999);
    check("t3.err13", key_err, 1'b1);
    step("t3.errpulse", 1'b0, 0, 1'b0);
    key("t3.clr", 17);

    // Backspace down past empty
    key("t4.k4", 4); key("t4.k5", 5); key("t4.k6", 6);
    for (int i = 0; i < 4; i++) key("t4.bksp", 18);

    // Rejections
    key("t5.eqA", 15);
    key("t5.inv25", 25);
    key("t5.add", 10); key("t5.k1", 1); key("t5.div", 13);
    key("t5.clr", 17);

    // Asynchronous reset while issuing
    key("t6.k3", 3); key("t6.pow", 14); key("t6.k2", 2); key("t6.eq", 15);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_clear_all();
    m_err = 0;
    check("t6.async_op_valid", op_valid, 1'b0);
    check("t6.async_a", a, 0);
    check("t6.async_b", b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    key("t6.k0", 0); key("t6.k0b", 0); key("t6.k8", 8);
    check("t6.disp8", disp_value, 8);
    key("t6.clr", 17);

    // Randomized key stream
    for (int i = 0; i < 1500; i++) begin
      bit kv, ordy;
      int code;
      kv   = ($urandom % 4) != 0;
      ordy = ($urandom % 3) == 0;
      if (($urandom % 10) < 6) code = $urandom % 10;
      else                     code = $urandom_range(10, 31);
      step("rand", kv, code, ordy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_key_entry.md
Name: calc_key_entry

Overview:
- Upstream operand-entry stage for the 12-digit signed calculator core.
- Accepts one key code per handshake and builds operand A, an operator and operand B in decimal, digit by digit.
- Presents {a, b, operand} to the combinational calculator with a valid/ready handshake.
- Drives a display value for the operand currently being entered.

Parameters:
- NB, 48, operand width in bits (signed two's complement); must satisfy 10**NDIG-1 < 2**(NB-1).
- NDIG, 12, maximum decimal digits per operand.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  key code present.
- key_code  in  5  0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 DIV, 14 POW, 15 EQ, 16 NEG, 17 CLR, 18 BKSP, 19-31 invalid.
- key_ready  out  1  entry can accept a key.
- a  out  NB  signed operand A to the core.
- b  out  NB  signed operand B to the core.
- operand  out  3  operator code to the core: 0 add, 1 sub, 2 mul, 3 div, 4 pow.
- op_valid  out  1  {a, b, operand} complete and stable.
- op_ready  in  1  core/result stage consumes the operation.
- disp_value  out  NB  signed value of the operand under entry.
- key_err  out  1  one-cycle pulse when a key is rejected.

Behaviour:
- Reset: async on rst_n low. State ENTRY_A; a, b, disp_value, magnitude, digit count = 0; sign = +; operand = 0; op_valid = 0; key_err = 0.
- Key acceptance:
  - A key is accepted when key_valid & key_ready; one key per cycle; effects are visible the next cycle.
  - key_ready = 1 in ENTRY_A and ENTRY_B, 0 in ISSUE. key_ready is combinational from state only.
- States:
  - ENTRY_A -> ENTRY_B on an operator key (10-14). Latches operand = key_code - 10 and freezes a. An operator with zero digits gives a = 0.
  - ENTRY_B -> ISSUE on EQ. b = entered value; b = 0 if no digits were entered.
  - ENTRY_B, operator key with zero B digits: replaces operand. With B digits present: rejected with key_err.
  - ENTRY_A, EQ: rejected with key_err.
  - ISSUE: op_valid = 1 and a, b, operand held constant. On op_valid & op_ready, next cycle: op_valid = 0 and state = ENTRY_A with everything cleared as at reset.
- Digit key:
  - If count < NDIG: mag = mag*10 + d and count++.
  - Leading zero with count == 0: mag stays 0 and count stays 0 (not rejected).
  - If count == NDIG: rejected, value unchanged, key_err pulse.
- NEG toggles the sign of the current operand. Allowed at any count, including 0 (shown as 0). disp_value = sign ? -mag : mag.
- BKSP: mag = mag/10 and count-- if count > 0. At count 0: no-op, no error. Sign is kept.
- CLR: returns to ENTRY_A with all fields cleared, from ENTRY_A or ENTRY_B.
- Invalid codes 19-31: rejected with key_err.
- Arithmetic:
  - mag is unsigned NB bits, never exceeds 10**NDIG-1, so there is no overflow.
  - Multiply by 10 is implemented as shift-add (mag<<3 + mag<<1).
  - Divide by 10 is a constant division in a single cycle.
- key_err is registered, high for exactly the cycle after the rejected key.
- Reset mid-operation (including ISSUE with op_valid high) drops op_valid immediately and asynchronously. No partial operation survives.

Decomposition:
- Package calc_pkg:
  - key_code_e enum (values above).
  - calc_op_e enum {OP_ADD=0, OP_SUB, OP_MUL, OP_DIV, OP_POW}.
  - entry_state_e {ENTRY_A, ENTRY_B, ISSUE}.
  - Constants NB_DEF = 48 and NDIG_DEF = 12, shared with the calculator core.
- Sub-module calc_digit_acc:
  - Holds mag, count and sign.
  - Commands: push digit, backspace, negate, clear.
  - Outputs the signed value and a full flag.
  - One instance, reused for A then B; a is latched out of it on the operator key.

Test Plan:
- Keys 1,2,ADD,3,4,EQ -> op_valid=1, a=12, b=34, operand=0; hold op_ready=0 for 5 cycles -> outputs stable and key_ready=0; op_ready=1 -> ENTRY_A, disp_value=0.
- Keys 7,NEG,SUB,MUL,5,EQ -> a=-7, operand=2 (operator replaced, no key_err), b=5.
- Thirteen '9' keys -> disp_value=999999999999, key_err pulses once on the 13th key only.
- Keys 4,5,6,BKSP,BKSP,BKSP,BKSP -> disp_value 456,45,4,0,0; no key_err.
- EQ in ENTRY_A, key_code=25, and ADD,1,DIV -> key_err on each; state, a and b unchanged.
- Keys 3,POW,2,EQ then rst_n low in ISSUE -> op_valid=0 asynchronously, a=b=0; after release, keys 0,0,8 -> disp_value=8.
